ral_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the RAL register bank bus (addr, wr_en, wdata, rdata).
- Accepts one access per requester at a time.
- Arbitrates round-robin and drives a single bus transaction.
- Captures read data one cycle after the bank's clocked read.
- Returns a per-requester done pulse with data or error.
- Sits between the host-side register agents and the four-register bank at BASE_ADDR.

---
 rtl/ral_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ral_bus_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ral_bus_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the four-register RAL bank.
// Define RAL_ARB_FIXED_PRIO_EN to make requester 0 win every tie.

module ral_arb_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic                  issue,
    input  logic                  resp,
    input  logic                  err_path,
    input  logic [DATA_WIDTH-1:0] cap_data,
    output logic                  gnt,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] hold_q;

    // The error path skips ISSUE, so its grant rides along with the response.
    assign gnt   = sel & (issue | (resp & err_path));
    assign done  = sel & resp;
    assign err   = done & err_path;
    assign rdata = done ? cap_data : hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     hold_q <= '0;
        else if (done) hold_q <= cap_data;
    end
endmodule

module ral_bus_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata
);
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t                 state, state_nxt;
    req_t [NUM_REQ-1:0]     req_in;
    req_t                   cur_q, win_req;
    logic                   owner_q, err_q, win, any_req, addr_ok;
    logic [DATA_WIDTH-1:0]  cap_q;
    logic [NUM_REQ-1:0]     gnt_v, done_v, err_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_v;
`ifndef RAL_ARB_FIXED_PRIO_EN
    logic                   last_owner_q;
`endif

    assign req_in[0] = {m0_wr, m0_addr, m0_wdata};
    assign req_in[1] = {m1_wr, m1_addr, m1_wdata};
    assign any_req   = m0_req | m1_req;

    always_comb begin
`ifdef RAL_ARB_FIXED_PRIO_EN
        win = (m0_req & m1_req) ? 1'b0 : m1_req;
`else
        win = (m0_req & m1_req) ? ~last_owner_q : m1_req;
`endif
        win_req = req_in[win];
        addr_ok = (win_req.addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]) &&
                  (win_req.addr[1:0] == 2'b00);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = addr_ok ? ISSUE : RESP;
            ISSUE:   state_nxt = cur_q.wr ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur_q   <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            cap_q   <= '0;
`ifndef RAL_ARB_FIXED_PRIO_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                cur_q   <= win_req;
                owner_q <= win;
                err_q   <= ~addr_ok;
                // Cleared here so writes and errors respond with zero data.
                cap_q   <= '0;
`ifndef RAL_ARB_FIXED_PRIO_EN
                last_owner_q <= win;
`endif
            end
            if (state == CAPTURE) cap_q <= reg_rdata;
        end
    end

    always_comb begin
        reg_addr  = '0;
        reg_wr_en = 1'b0;
        reg_wdata = '0;
        if (state == ISSUE || state == CAPTURE) begin
            reg_addr  = cur_q.addr;
            reg_wdata = cur_q.wdata;
            reg_wr_en = (state == ISSUE) & cur_q.wr;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        ral_arb_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
            .clk      (clk),
            .reset    (reset),
            .sel      (owner_q == 1'(i)),
            .issue    (state == ISSUE),
            .resp     (state == RESP),
            .err_path (err_q),
            .cap_data (cap_q),
            .gnt      (gnt_v[i]),
            .done     (done_v[i]),
            .err      (err_v[i]),
            .rdata    (rdata_v[i])
        );
    end

    assign m0_gnt   = gnt_v[0];
    assign m0_done  = done_v[0];
    assign m0_err   = err_v[0];
    assign m0_rdata = rdata_v[0];
    assign m1_gnt   = gnt_v[1];
    assign m1_done  = done_v[1];
    assign m1_err   = err_v[1];
    assign m1_rdata = rdata_v[1];
endmodule

// File: tb/tb_ral_bus_arbiter.sv
// Random and directed bench for ral_bus_arbiter with a transaction-level
// reference model and a clocked four-register bank.

module tb_ral_bus_arbiter;
    localparam logic [31:0] BASE = 32'h400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0, wr = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  gnt, done, err;
    logic [31:0] rdata [2];
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        reg_wr_en;
    logic [31:0] bank [4];

    // reference model state
    bit          p_req [2];
    bit          p_wr [2];
    logic [31:0] p_addr [2], p_wdata [2], hold [2], mem [4];
    int          last;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    ral_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_wr(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(gnt[0]), .m0_done(done[0]), .m0_err(err[0]), .m0_rdata(rdata[0]),
        .m1_req(req[1]), .m1_wr(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(gnt[1]), .m1_done(done[1]), .m1_err(err[1]), .m1_rdata(rdata[1]),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata)
    );

    // register bank: clocked read, read data appears on the sampling edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) bank[i] <= '0;
            reg_rdata <= '0;
        end else if (reg_wr_en) bank[reg_addr[3:2]] <= reg_wdata;
        else reg_rdata <= bank[reg_addr[3:2]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        last = 1;
        for (int i = 0; i < 2; i++) begin
            hold[i] = '0; p_req[i] = 1'b0; req[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) mem[i] = '0;
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_m%0d_ctl", tag, i), {61'd0, gnt[i], done[i], err[i]}, 64'd0);
            chk($sformatf("%s_m%0d_rdata", tag, i), {32'd0, rdata[i]}, {32'd0, hold[i]});
        end
        chk({tag, "_bus"}, {31'd0, reg_wr_en, reg_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, reg_wdata}, 64'd0);
    endtask

    task automatic post(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        p_req[i] = 1'b1; p_wr[i] = w; p_addr[i] = a; p_wdata[i] = d;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
    endtask

    // One arbitration round; entered and left at a falling edge in IDLE.
    task automatic serve();
        int          w, lat, idx;
        bit          e, tw;
        logic [31:0] a, d, rexp;
        logic [2:0]  ctl;
        logic [31:0] rd;
        if (!p_req[0] && !p_req[1]) begin
            @(posedge clk); @(negedge clk);
            chk_idle("quiet");
            return;
        end
        if (p_req[0] && p_req[1]) begin
`ifdef RAL_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (last == 0) ? 1 : 0;
`endif
        end else w = p_req[1] ? 1 : 0;
        last = w;
        a = p_addr[w]; tw = p_wr[w]; d = p_wdata[w];
        e = !(a >= BASE && a <= BASE + 32'd12 && (a % 4) == 0);
        lat = e ? 1 : (tw ? 2 : 3);
        idx = int'((a - BASE) / 4) & 3;
        rexp = (e || tw) ? 32'd0 : mem[idx];
        if (!e && tw) mem[idx] = d;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                ctl = (i == w) ? {k == 1, k == lat, (k == lat) && e} : 3'b000;
                rd  = (i == w && k == lat) ? rexp : hold[i];
                chk($sformatf("c%0d_m%0d_ctl", k, i), {61'd0, gnt[i], done[i], err[i]}, {61'd0, ctl});
                chk($sformatf("c%0d_m%0d_rdata", k, i), {32'd0, rdata[i]}, {32'd0, rd});
            end
            chk($sformatf("c%0d_bus", k), {31'd0, reg_wr_en, reg_addr},
                {31'd0, (k == 1) && tw && !e,
                 (!e && (k == 1 || (k == 2 && !tw))) ? a : 32'd0});
            if (k == 1) begin
                chk("c1_wdata", {32'd0, reg_wdata}, {32'd0, e ? 32'd0 : d});
                req[w] = 1'b0; p_req[w] = 1'b0;
            end
        end
        hold[w] = rexp;
        @(posedge clk); @(negedge clk);
        chk_idle("back");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1 chk_idle("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int s = $urandom_range(7);
        if (s <= 5) return BASE + 32'(4 * $urandom_range(3));
        if (s == 6) return BASE + 32'($urandom_range(15));
        return $urandom;
    endfunction

    initial begin
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_idle("reset_state");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // reset while a read sits in CAPTURE
        post(0, 1'b0, BASE + 32'h4, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rmr_gnt", {63'd0, gnt[0]}, 64'd1);
        req[0] = 1'b0; p_req[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        do_reset();
        repeat (3) begin @(negedge clk); chk_idle("rmr_after"); end

        // write then read back from the other requester
        post(0, 1'b1, BASE, 32'hDEAD_BEEF); serve();
        post(1, 1'b0, BASE, 32'd0);         serve();

        // simultaneous requests from reset
        @(negedge clk);
        do_reset();
        post(0, 1'b0, BASE + 32'h4, 32'd0);
        post(1, 1'b0, BASE + 32'h8, 32'd0);
        serve();
        post(0, 1'b0, BASE + 32'hC, 32'd0);
        serve(); serve();
        repeat (2) serve();

        // address errors
        post(1, 1'b0, 32'h410, 32'd0); serve();
        post(1, 1'b0, 32'h402, 32'd0); serve();

        // alternating writes then readback
        post(0, 1'b1, BASE + 32'h4, 32'd1); serve();
        post(1, 1'b1, BASE + 32'h8, 32'd2); serve();
        post(0, 1'b1, BASE + 32'hC, 32'd3); serve();
        post(1, 1'b0, BASE + 32'h4, 32'd0); serve();
        post(0, 1'b0, BASE + 32'h8, 32'd0); serve();
        post(1, 1'b0, BASE + 32'hC, 32'd0); serve();
        post(0, 1'b0, BASE,         32'd0); serve();

        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 2; i++)
                if (!p_req[i] && $urandom_range(9) < 6)
                    post(i, 1'($urandom_range(1)), rnd_addr(), $urandom);
            serve();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
